// File: rtl/motor_act_pkg.sv
// rtl/motor_act_pkg.sv - shared defaults and skid-buffer state type for the motor activation stage
package motor_act_pkg;

  localparam int unsigned MOTOR_W  = 32;
  localparam int unsigned MOTOR_I  = 8;
  localparam int unsigned MOTOR_N  = 4;
  localparam int unsigned MOTOR_CW = 16;
  localparam int unsigned LEAK_W   = 4;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_e;

endpackage

// File: rtl/motor_relu_lane.sv
// rtl/motor_relu_lane.sv - single-channel ReLU / leaky ReLU, optional ReLU-N clip under RELU_CLIP_EN
module motor_relu_lane
  import motor_act_pkg::*;
#(
  parameter int unsigned W = MOTOR_W
) (
  input  logic signed [W-1:0]      x_i,
  input  logic        [LEAK_W-1:0] leak_shift_i,
`ifdef RELU_CLIP_EN
  input  logic        [W-2:0]      clip_val_i,
`endif
  output logic        [W-1:0]      y_o,
  output logic                     nonpos_o
);

  always_comb begin
    nonpos_o = x_i[W-1] || (x_i == '0);
    y_o      = '0;
    if (!nonpos_o) begin
      y_o = x_i;
`ifdef RELU_CLIP_EN
      // x is positive here, so its low W-1 bits are its magnitude
      if (x_i[W-2:0] > clip_val_i) begin
        y_o = {1'b0, clip_val_i};
      end
`endif
    end else if (leak_shift_i != '0) begin
      y_o = x_i >>> leak_shift_i;
    end
  end

endmodule

// File: rtl/motor_relu_stream.sv
// rtl/motor_relu_stream.sv - streaming N-channel ReLU stage behind a two-entry skid buffer (RELU_CLIP_EN adds clip_val)
module motor_relu_stream
  import motor_act_pkg::*;
#(
  parameter int unsigned W  = MOTOR_W,
  parameter int unsigned I  = MOTOR_I,
  parameter int unsigned N  = MOTOR_N,
  parameter int unsigned CW = MOTOR_CW
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [N*W-1:0]    s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [N*W-1:0]    m_data,
  input  logic [LEAK_W-1:0] leak_shift,
`ifdef RELU_CLIP_EN
  input  logic [W-2:0]      clip_val,
`endif
  input  logic              cnt_clr,
  output logic [CW-1:0]     np_count
);

  localparam int unsigned SW = CW + 1;

  skid_state_e       state_q;
  logic [N*W-1:0]    main_q, skid_q;
  logic              s_ready_q, m_valid_q;
  logic [CW-1:0]     np_count_q, np_count_d;
  logic [N*W-1:0]    lane_y;
  logic [N-1:0]      lane_np;
  logic [7:0]        np_beat;
  logic [SW-1:0]     np_sum;
  logic              accept;

  assign accept = s_valid && s_ready_q;

  for (genvar k = 0; k < N; k++) begin : g_lane
    motor_relu_lane #(.W(W)) u_lane (
      .x_i          (s_data[k*W +: W]),
      .leak_shift_i (leak_shift),
`ifdef RELU_CLIP_EN
      .clip_val_i   (clip_val),
`endif
      .y_o          (lane_y[k*W +: W]),
      .nonpos_o     (lane_np[k])
    );
  end

  always_comb begin
    np_beat = '0;
    for (int k = 0; k < N; k++) begin
      np_beat = np_beat + 8'(lane_np[k]);
    end
  end

  // One guard bit above the counter catches the saturating carry
  assign np_sum = {1'b0, np_count_q} + SW'(np_beat);

  always_comb begin
    np_count_d = np_count_q;
    if (cnt_clr) begin
      np_count_d = '0;
    end else if (accept) begin
      np_count_d = np_sum[CW] ? '1 : np_sum[CW-1:0];
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      np_count_q <= '0;
    end else begin
      np_count_q <= np_count_d;
    end
  end

  // s_ready tracks the next state so it is low the cycle after entering TWO
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q   <= EMPTY;
      main_q    <= '0;
      skid_q    <= '0;
      s_ready_q <= 1'b0;
      m_valid_q <= 1'b0;
    end else begin
      case (state_q)
        EMPTY: begin
          s_ready_q <= 1'b1;
          if (accept) begin
            main_q    <= lane_y;
            state_q   <= ONE;
            m_valid_q <= 1'b1;
          end
        end
        ONE: begin
          if (accept && m_ready) begin
            main_q <= lane_y;
          end else if (accept) begin
            skid_q    <= lane_y;
            state_q   <= TWO;
            s_ready_q <= 1'b0;
          end else if (m_ready) begin
            state_q   <= EMPTY;
            m_valid_q <= 1'b0;
          end
        end
        TWO: begin
          if (m_ready) begin
            main_q    <= skid_q;
            state_q   <= ONE;
            s_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q   <= EMPTY;
          s_ready_q <= 1'b1;
          m_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign s_ready  = s_ready_q;
  assign m_valid  = m_valid_q;
  assign m_data   = main_q;
  assign np_count = np_count_q;

endmodule

// File: tb/tb_motor_relu_stream.sv
// tb/tb_motor_relu_stream.sv - scoreboard bench for motor_relu_stream (RELU_CLIP_EN optional)
module tb_motor_relu_stream;

  localparam int W   = 32;
  localparam int N   = 4;
  localparam int DW  = N * W;
  localparam int CW  = 16;
  localparam int CWS = 4;

  logic           ap_clk = 1'b0;
  logic           ap_rst_n = 1'b1;
  logic           s_valid = 1'b0;
  logic           m_ready = 1'b0;
  logic           cnt_clr = 1'b0;
  logic [DW-1:0]  s_data = '0;
  logic [3:0]     leak_shift = '0;
  logic [W-2:0]   clip_val = '1;

  logic           s_ready, m_valid, s_ready_s, m_valid_s;
  logic [DW-1:0]  m_data, m_data_s;
  logic [CW-1:0]  np_count;
  logic [CWS-1:0] np_count_s;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];
  longint cnt_big = 0;
  longint cnt_small = 0;

  motor_relu_stream #(.W(W), .I(8), .N(N), .CW(CW)) u_dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .leak_shift(leak_shift),
`ifdef RELU_CLIP_EN
    .clip_val(clip_val),
`endif
    .cnt_clr(cnt_clr), .np_count(np_count)
  );

  motor_relu_stream #(.W(W), .I(8), .N(N), .CW(CWS)) u_dut_cw4 (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .s_valid(s_valid), .s_ready(s_ready_s),
    .s_data(s_data), .m_valid(m_valid_s), .m_ready(m_ready), .m_data(m_data_s),
    .leak_shift(leak_shift),
`ifdef RELU_CLIP_EN
    .clip_val(clip_val),
`endif
    .cnt_clr(cnt_clr), .np_count(np_count_s)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: ReLU from the real-valued rule, leaky slope as floor division by 2^k
  function automatic logic [W-1:0] ref_chan(input logic [W-1:0] xb, input int ls);
    longint x, y, d;
    x = longint'($signed(xb));
    d = longint'(1) << ls;
    if (x > 0) begin
      y = x;
`ifdef RELU_CLIP_EN
      if (y > longint'(clip_val)) y = longint'(clip_val);
`endif
    end else if (ls == 0) begin
      y = 0;
    end else begin
      y = -((-x + d - 1) / d);
    end
    return y[W-1:0];
  endfunction

  function automatic logic [DW-1:0] ref_beat(input logic [DW-1:0] d, input int ls);
    logic [DW-1:0] r;
    for (int k = 0; k < N; k++) r[k*W +: W] = ref_chan(d[k*W +: W], ls);
    return r;
  endfunction

  function automatic int nonpos_cnt(input logic [DW-1:0] d);
    int n = 0;
    for (int k = 0; k < N; k++) if ($signed(d[k*W +: W]) <= 0) n++;
    return n;
  endfunction

  function automatic logic [DW-1:0] rand_beat(input bit all_neg);
    logic [DW-1:0] r;
    for (int k = 0; k < N; k++) begin
      case ($urandom_range(0, 4))
        0: r[k*W +: W] = '0;
        1: r[k*W +: W] = 32'hFFFFFFFF;
        default: r[k*W +: W] = $urandom;
      endcase
      if (all_neg) r[k*W + W - 1] = 1'b1;
    end
    return r;
  endfunction

  // Called just after a rising edge; returns just after the edge that accepted the beat
  task automatic send_beat(input logic [DW-1:0] d, input logic [3:0] ls, input logic clr);
    bit done = 0;
    s_data = d;
    leak_shift = ls;
    cnt_clr = clr;
    s_valid = 1'b1;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge ap_clk);
      if (s_ready) begin
        exp_q.push_back(ref_beat(d, int'(ls)));
        done = 1;
      end
      @(posedge ap_clk);
      #1;
    end
    s_valid = 1'b0;
    cnt_clr = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no s_ready expected accept within 200 cycles");
    end
  endtask

  always @(negedge ap_clk) begin
    if (!ap_rst_n) begin
      cnt_big = 0;
      cnt_small = 0;
    end
    check("np_count", DW'(np_count), DW'(cnt_big));
    check("np_count_cw4", DW'(np_count_s), DW'(cnt_small));
    if (ap_rst_n) begin
      if (cnt_clr) begin
        cnt_big = 0;
        cnt_small = 0;
      end else if (s_valid && s_ready) begin
        cnt_big = cnt_big + nonpos_cnt(s_data);
        cnt_small = cnt_small + nonpos_cnt(s_data);
        if (cnt_big > 65535) cnt_big = 65535;
        if (cnt_small > 15) cnt_small = 15;
      end
    end
  end

  always @(negedge ap_clk) begin
    if (ap_rst_n && m_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL m_data_extra: got beat %h expected no beat", m_data);
      end else if (m_ready) begin
        check("m_data", m_data, exp_q.pop_front());
      end else begin
        check("m_data_hold", m_data, exp_q[0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] b1, b2, b3, nb;
    bit rdone;

    #2 ap_rst_n = 1'b0;
    repeat (2) @(negedge ap_clk);
    check("rst_m_valid", DW'(m_valid), '0);
    check("rst_s_ready", DW'(s_ready), '0);
    check("rst_m_data", m_data, '0);
    @(posedge ap_clk); #1 ap_rst_n = 1'b1;
    @(negedge ap_clk);
    check("s_ready_pre_edge", DW'(s_ready), '0);
    @(posedge ap_clk); #1;
    check("s_ready_post_edge", DW'(s_ready), DW'(1));

    m_ready = 1'b1;
    cnt_clr = 1'b1;
    @(posedge ap_clk); #1 cnt_clr = 1'b0;
    send_beat({32'h7FFFFFFF, 32'h0, 32'hFF000000, 32'h01000000}, 4'd0, 1'b0);
    check("latency_valid", DW'(m_valid), DW'(1));
    check("relu_data", m_data, {32'h7FFFFFFF, 32'h0, 32'h0, 32'h01000000});
    check("relu_np_count", DW'(np_count), DW'(2));

    send_beat({32'h0, 32'h0, 32'hFFFFFFFF, 32'hF8000000}, 4'd3, 1'b0);
    check("leaky_data", m_data, {32'h0, 32'h0, 32'hFFFFFFFF, 32'hFF000000});
    @(posedge ap_clk); #1;

    m_ready = 1'b0;
    b1 = rand_beat(0);
    b2 = rand_beat(0);
    b3 = rand_beat(0);
    send_beat(b1, 4'd1, 1'b0);
    send_beat(b2, 4'd2, 1'b0);
    check("bp_s_ready_low", DW'(s_ready), '0);
    check("bp_m_valid", DW'(m_valid), DW'(1));
    check("bp_holds_beat1", m_data, ref_beat(b1, 1));
    fork
      send_beat(b3, 4'd0, 1'b0);
      begin
        repeat (3) @(posedge ap_clk);
        #1 m_ready = 1'b1;
      end
    join
    repeat (3) @(posedge ap_clk);
    #1;
    check("bp_drained", DW'(exp_q.size()), '0);

    clip_val = 31'h06000000;
    send_beat({32'h0, 32'h0, 32'h02000000, 32'h07800000}, 4'd0, 1'b0);
`ifdef RELU_CLIP_EN
    check("clip_data", m_data, {32'h0, 32'h0, 32'h02000000, 32'h06000000});
`else
    check("noclip_data", m_data, {32'h0, 32'h0, 32'h02000000, 32'h07800000});
`endif

    cnt_clr = 1'b1;
    @(posedge ap_clk); #1 cnt_clr = 1'b0;
    for (int i = 0; i < 5; i++) send_beat(rand_beat(1), 4'd0, 1'b0);
    check("sat_cw4", DW'(np_count_s), DW'(15));
    check("count_cw16", DW'(np_count), DW'(20));
    send_beat(rand_beat(1), 4'd0, 1'b1);
    check("clr_wins_cw4", DW'(np_count_s), '0);
    check("clr_wins_cw16", DW'(np_count), '0);

    clip_val = 31'h40000000;
    rdone = 0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          nb = rand_beat(0);
          send_beat(nb, ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 15)),
                    ($urandom_range(0, 15) == 0));
          if ($urandom_range(0, 3) == 0) begin
            @(posedge ap_clk);
            #1;
          end
        end
        rdone = 1;
      end
      begin
        while (!rdone) begin
          @(posedge ap_clk);
          #1 m_ready = ($urandom_range(0, 2) != 0);
        end
      end
    join
    m_ready = 1'b1;
    for (int t = 0; t < 50 && exp_q.size() != 0; t++) @(posedge ap_clk);
    #1;
    check("random_drained", DW'(exp_q.size()), '0);

    @(posedge ap_clk); #1;
    m_ready = 1'b0;
    send_beat(rand_beat(0), 4'd0, 1'b0);
    send_beat(rand_beat(0), 4'd0, 1'b0);
    check("two_s_ready_low", DW'(s_ready), '0);
    ap_rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("midrst_m_valid", DW'(m_valid), '0);
    check("midrst_m_data", m_data, '0);
    check("midrst_s_ready", DW'(s_ready), '0);
    @(posedge ap_clk); #1 ap_rst_n = 1'b1;
    @(negedge ap_clk);
    check("rel_s_ready_pre", DW'(s_ready), '0);
    @(posedge ap_clk); #1;
    check("rel_s_ready_post", DW'(s_ready), DW'(1));
    check("rel_m_valid", DW'(m_valid), '0);
    repeat (2) @(posedge ap_clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
